// File: rtl/inter_rm_wr_master_if.sv
// Bundles the AXI-Stream input and the AXI4 write-channel signals of the inter-RM write master.
// Latency: none (wires only).
// Backpressure: carried by the valid/ready pairs; master = write master block, slave = stream source plus AXI4 write slave.
// Ports: s_axis_* stream in, m_axi_aw* address, m_axi_w* data, m_axi_b* response.
interface inter_rm_wr_master_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 128
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_W-1:0]     s_axis_tdata;
    logic [DATA_W/8-1:0]   s_axis_tkeep;
    logic                  s_axis_tlast;

    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [ADDR_W-1:0]     m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;

    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [DATA_W-1:0]     m_axi_wdata;
    logic [DATA_W/8-1:0]   m_axi_wstrb;
    logic                  m_axi_wlast;

    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [1:0]            m_axi_bresp;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
        output s_axis_tready,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        input  m_axi_wready,
        input  m_axi_bvalid, m_axi_bresp,
        output m_axi_bready
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
        input  s_axis_tready,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        output m_axi_wready,
        output m_axi_bvalid, m_axi_bresp,
        input  m_axi_bready
    );
endinterface

// File: rtl/inter_rm_wr_master.sv
// AXI-Stream to AXI4 INCR burst write master: buffers up to MAX_BURST beats, then runs AW -> W -> B, one burst in flight.
// Latency: awvalid rises on the edge that accepts the tlast / buffer-filling beat; W beats stream from the buffer with no bubbles.
// Backpressure: s_axis_tready only in FILL with buffer space; AW/W outputs hold stable while awready/wready are low.
// Ports: clk, resetn (async active-low); bus (inter_rm_wr_master_if.master); busy; bresp_err (sticky on non-OKAY bresp).
// Optional: define INTER_RM_WR_FLUSH_EN to flush a partial buffer after FLUSH_CYCLES idle cycles.
module inter_rm_wr_master #(
    parameter int              DATA_W       = 128,
    parameter int              ADDR_W       = 30,
    parameter int              MAX_BURST    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int              FLUSH_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        resetn,
    inter_rm_wr_master_if.master        bus,
    output logic                        busy,
    output logic                        bresp_err
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int ENT_W  = DATA_W + KEEP_W;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int PTR_W  = $clog2(MAX_BURST);

    if (DATA_W != 128 || MAX_BURST < 2 || MAX_BURST > 256 || FLUSH_CYCLES < 1) begin : g_param_err
        $error("inter_rm_wr_master: unsupported parameter set");
    end

    typedef enum logic [1:0] {FILL, AW, W, B} state_t;

    state_t             state_q, state_d;
    logic               run_q;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               bresp_err_q;
    logic [ENT_W-1:0]   mem [MAX_BURST];

    logic               s_rdy;
    logic               beat_acc;
    logic               aw_vld;
    logic               w_vld;
    logic               w_last;
    logic               b_rdy;
    logic               rd_last;

    // run_q keeps tready low through reset and for the first edge after release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= FILL;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

`ifdef INTER_RM_WR_FLUSH_EN
    localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_q <= '0;
        end else if (state_q != FILL || beat_acc || count_q == '0) begin
            idle_q <= '0;
        end else if (idle_q != IDLE_W'(FLUSH_CYCLES)) begin
            idle_q <= idle_q + IDLE_W'(1);
        end
    end
`endif

    assign rd_last = (count_q == CNT_W'(rd_ptr_q) + CNT_W'(1));

    always_comb begin
        state_d  = state_q;
        s_rdy    = 1'b0;
        beat_acc = 1'b0;
        aw_vld   = 1'b0;
        w_vld    = 1'b0;
        w_last   = 1'b0;
        b_rdy    = 1'b0;
        case (state_q)
            FILL: begin
                s_rdy    = run_q && (count_q < CNT_W'(MAX_BURST));
                beat_acc = s_rdy && bus.s_axis_tvalid;
                // The trigger beat is written this edge, so it is part of the burst.
                if (beat_acc && (bus.s_axis_tlast || count_q == CNT_W'(MAX_BURST - 1))) begin
                    state_d = AW;
                end
`ifdef INTER_RM_WR_FLUSH_EN
                // Counter would reach FLUSH_CYCLES on this edge.
                else if (!beat_acc && count_q != '0 && idle_q == IDLE_W'(FLUSH_CYCLES - 1)) begin
                    state_d = AW;
                end
`endif
            end
            AW: begin
                aw_vld = 1'b1;
                if (bus.m_axi_awready) state_d = W;
            end
            W: begin
                w_vld  = 1'b1;
                w_last = rd_last;
                if (bus.m_axi_wready && rd_last) state_d = B;
            end
            B: begin
                b_rdy = 1'b1;
                if (bus.m_axi_bvalid) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            addr_q      <= BASE_ADDR;
            bresp_err_q <= 1'b0;
        end else begin
            if (beat_acc) count_q <= count_q + CNT_W'(1);
            if (state_q == W && bus.m_axi_wready) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (state_q == B && bus.m_axi_bvalid) begin
                if (bus.m_axi_bresp != 2'b00) bresp_err_q <= 1'b1;
                addr_q   <= addr_q + (ADDR_W'(count_q) << 4);
                count_q  <= '0;
                rd_ptr_q <= '0;
            end
        end
    end

    // Buffer storage needs no reset: count_q gates what is ever read.
    always_ff @(posedge clk) begin
        if (beat_acc) mem[count_q[PTR_W-1:0]] <= {bus.s_axis_tkeep, bus.s_axis_tdata};
    end

    assign bus.s_axis_tready = s_rdy;
    assign bus.m_axi_awvalid = aw_vld;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awlen   = 8'(count_q - CNT_W'(1));
    assign bus.m_axi_awsize  = 3'b100;
    assign bus.m_axi_awburst = 2'b01;
    assign bus.m_axi_wvalid  = w_vld;
    // Combinational read of the head entry gives first-word-fall-through.
    assign bus.m_axi_wdata   = mem[rd_ptr_q][DATA_W-1:0];
    assign bus.m_axi_wstrb   = mem[rd_ptr_q][ENT_W-1:DATA_W];
    assign bus.m_axi_wlast   = w_last;
    assign bus.m_axi_bready  = b_rdy;

    assign busy      = (state_q != FILL) || (count_q != '0);
    assign bresp_err = bresp_err_q;
endmodule

// File: tb/tb_inter_rm_wr_master.sv
module tb_inter_rm_wr_master;
    localparam int              ADDR_W    = 30;
    localparam int              MAX_BURST = 16;
    localparam int              FLUSH     = 64;
    localparam logic [ADDR_W-1:0] BASE    = 30'h0000_1000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic busy, bresp_err;

    always #5 clk = ~clk;

    inter_rm_wr_master_if #(.ADDR_W(ADDR_W)) bus ();

    inter_rm_wr_master #(
        .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .BASE_ADDR(BASE), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .busy(busy), .bresp_err(bresp_err)
    );

    typedef struct { logic [127:0] d; logic [15:0] k; logic l; } beat_t;
    typedef struct { logic [ADDR_W-1:0] a; logic [7:0] len; int cyc; } aw_t;
    typedef struct {
        int len; bit last; int nb; int l0; int l1; int l2;
        int aw_stall; bit w_tog; int err_burst;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int seq = 0;
    int acc_cyc = 0;
    int b_cnt = 0;
    int err_b_idx = -1;
    int aw_stall_left = 0;
    bit w_tog_pend = 0;
    int w_since_aw = 0;
    bit aw_open = 0;
    bit aw_wait = 0;
    bit w_wait = 0;
    int aw_first = 0;
    logic [ADDR_W-1:0] aw_addr_h;
    logic [7:0] aw_len_h;
    logic [127:0] w_d_h;
    logic [15:0] w_k_h;
    logic [ADDR_W-1:0] exp_addr = BASE;
    logic exp_err = 1'b0;

    beat_t src_q[$];
    beat_t exp_q[$];
    beat_t w_q[$];
    aw_t   aw_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream source, AXI4 write slave and monitor. Outputs here do not depend combinationally
    // on inputs, so values read at this negedge are the ones the next posedge acts on.
    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            aw_wait = 0; w_wait = 0; aw_open = 0; w_since_aw = 0;
            bus.s_axis_tvalid = 1'b0;
            bus.m_axi_awready = 1'b0;
            bus.m_axi_wready  = 1'b0;
            bus.m_axi_bvalid  = 1'b0;
            bus.m_axi_bresp   = 2'b00;
        end else begin
            if (src_q.size() > 0) begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = src_q[0].d;
                bus.s_axis_tkeep  = src_q[0].k;
                bus.s_axis_tlast  = src_q[0].l;
                if (bus.s_axis_tready) begin
                    acc_cyc = cyc;
                    void'(src_q.pop_front());
                end
            end else begin
                bus.s_axis_tvalid = 1'b0;
            end

            bus.m_axi_awready = (aw_stall_left == 0);
            if (bus.m_axi_awvalid) begin
                if (aw_wait) begin
                    check("aw_addr_stable", bus.m_axi_awaddr, aw_addr_h);
                    check("aw_len_stable", bus.m_axi_awlen, aw_len_h);
                end else begin
                    aw_first = cyc;
                end
                if (bus.m_axi_awready) begin
                    aw_q.push_back('{bus.m_axi_awaddr, bus.m_axi_awlen, aw_first});
                    aw_wait = 0; aw_open = 1; w_since_aw = 0;
                end else begin
                    aw_wait = 1; aw_addr_h = bus.m_axi_awaddr; aw_len_h = bus.m_axi_awlen;
                    aw_stall_left--;
                end
            end

            bus.m_axi_wready = 1'b1;
            if (bus.m_axi_wvalid && w_tog_pend && w_since_aw == 1) begin
                bus.m_axi_wready = 1'b0;
                w_tog_pend = 0;
            end
            if (bus.m_axi_wvalid) begin
                if (w_wait) begin
                    check("wdata_stable", bus.m_axi_wdata, w_d_h);
                    check("wstrb_stable", bus.m_axi_wstrb, w_k_h);
                end
                if (bus.m_axi_wready) begin
                    check("w_after_aw", aw_open, 1'b1);
                    w_q.push_back('{bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_wlast});
                    w_wait = 0; w_since_aw++;
                end else begin
                    w_wait = 1; w_d_h = bus.m_axi_wdata; w_k_h = bus.m_axi_wstrb;
                end
            end

            bus.m_axi_bvalid = 1'b1;
            bus.m_axi_bresp  = (b_cnt == err_b_idx) ? 2'b10 : 2'b00;
            if (bus.m_axi_bready) begin
                b_cnt++;
                aw_open = 0;
            end
        end
    end

    function automatic vec_t mk(input int len, input bit last, input int nb, input int l0, input int l1,
                                input int l2, input int st, input bit tog, input int eb);
        vec_t v;
        v.len = len; v.last = last; v.nb = nb; v.l0 = l0; v.l1 = l1; v.l2 = l2;
        v.aw_stall = st; v.w_tog = tog; v.err_burst = eb;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int n, input bit last);
        beat_t bt;
        for (int i = 0; i < n; i++) begin
            seq++;
            bt.d = 128'(seq);
            bt.k = (seq <= 4) ? 16'hFFFF : 16'(32'hA5C3 ^ (seq << 3));
            bt.l = last && (i == n - 1);
            src_q.push_back(bt);
            exp_q.push_back(bt);
        end
    endtask

    // Waits for v.nb write responses, then checks each burst against the expected lengths.
    task automatic collect(input vec_t v);
        int b0;
        int lens[3];
        aw_t aw;
        beat_t wb, eb;
        b0 = b_cnt;
        lens[0] = v.l0; lens[1] = v.l1; lens[2] = v.l2;
        aw_stall_left = v.aw_stall;
        w_tog_pend = v.w_tog;
        err_b_idx = (v.err_burst >= 0) ? b0 + v.err_burst : -1;
        for (int t = 0; t < 3000 && (b_cnt - b0) < v.nb; t++) tick(1);
        check("burst_done", b_cnt - b0, v.nb);
        tick(3);
        check("burst_count", aw_q.size(), v.nb);
        for (int j = 0; j < v.nb && aw_q.size() > 0; j++) begin
            aw = aw_q.pop_front();
            check("awaddr", aw.a, exp_addr);
            check("awlen", aw.len, lens[j]);
            for (int b = 0; b <= lens[j]; b++) begin
                if (w_q.size() == 0 || exp_q.size() == 0) begin
                    check("w_beat_present", w_q.size(), 1);
                    break;
                end
                wb = w_q.pop_front();
                eb = exp_q.pop_front();
                check("wdata", wb.d, eb.d);
                check("wstrb", wb.k, eb.k);
                check("wlast", wb.l, (b == lens[j]));
            end
            exp_addr = exp_addr + ADDR_W'((lens[j] + 1) * 16);
            if (j == v.nb - 1) begin
`ifdef INTER_RM_WR_FLUSH_EN
                // Last beat sampled at acc_cyc is taken on the following edge; awvalid
                // rises FLUSH edges later when the packet is left open.
                check("aw_turnaround", aw.cyc - acc_cyc, v.last ? 1 : FLUSH + 1);
`else
                check("aw_turnaround", aw.cyc - acc_cyc, 1);
`endif
            end
        end
        check("w_leftover", w_q.size(), 0);
        if (v.err_burst >= 0) exp_err = 1'b1;
        err_b_idx = -1;
        check("bresp_err", bresp_err, exp_err);
        check("busy_idle", busy, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_tready"}, bus.s_axis_tready, 1'b0);
        check({tag, "_awvalid"}, bus.m_axi_awvalid, 1'b0);
        check({tag, "_wvalid"}, bus.m_axi_wvalid, 1'b0);
        check({tag, "_wlast"}, bus.m_axi_wlast, 1'b0);
        check({tag, "_bready"}, bus.m_axi_bready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_bresp_err"}, bresp_err, 1'b0);
    endtask

    vec_t vt[6];

    initial begin
        // len, last, bursts, awlen per burst, awready stall, wready toggle, error burst index
        vt[0] = mk(4,  1, 1, 3,  0,  0, 0,  0, -1);
        vt[1] = mk(40, 1, 3, 15, 15, 7, 0,  0, 1);
        vt[2] = mk(8,  1, 1, 7,  0,  0, 10, 1, -1);
        vt[3] = mk(1,  1, 1, 0,  0,  0, 0,  0, -1);
        vt[4] = mk(16, 1, 1, 15, 0,  0, 0,  0, -1);
        vt[5] = mk(17, 1, 2, 15, 0,  0, 0,  0, -1);

        tick(3);
        check_quiet("reset");
        check("reset_awsize", bus.m_axi_awsize, 3'b100);
        check("reset_awburst", bus.m_axi_awburst, 2'b01);
        resetn = 1'b1;
        tick(2);
        check("tready_idle", bus.s_axis_tready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            push_beats(vt[i].len, vt[i].last);
            collect(vt[i]);
        end

        // Reset in the middle of a burst: nothing of it may appear afterwards.
        push_beats(8, 1);
        for (int t = 0; t < 500 && w_q.size() < 2; t++) tick(1);
        check("w_two_beats", w_q.size(), 2);
        resetn = 1'b0;
        src_q.delete();
        exp_q.delete();
        tick(1);
        check_quiet("midreset");
        tick(2);
        resetn = 1'b1;
        aw_q.delete();
        w_q.delete();
        exp_addr = BASE;
        exp_err = 1'b0;
        tick(20);
        check("no_stale_aw", aw_q.size(), 0);
        check("no_stale_w", w_q.size(), 0);
        push_beats(1, 1);
        collect(mk(1, 1, 1, 0, 0, 0, 0, 0, -1));

        // Open packet with no tlast.
        push_beats(3, 0);
`ifdef INTER_RM_WR_FLUSH_EN
        collect(mk(3, 0, 1, 2, 0, 0, 0, 0, -1));
`else
        tick(150);
        check("no_flush_aw", aw_q.size(), 0);
        check("no_flush_busy", busy, 1'b1);
        push_beats(1, 1);
        collect(mk(4, 1, 1, 3, 0, 0, 0, 0, -1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
